dtc_vote_accum: RTL and testbench
=================================

DTC_VOTE_ACCUM -- requirements
Module: dtc_vote_accum

Interface
REQ-001 SHALL have parameter WINDOW, default 8, meaning the number of classifier samples per vote window (legal range 2..255).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inp  input  3  class code from the upstream decision-tree classifier.
REQ-005 SHALL have port in_valid  input  1  inp is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-007 SHALL have port flush  input  1  close the current window early.
REQ-008 SHALL have port outp  output  3  winning class of the closed window.
REQ-009 SHALL have port out_count  output  8  vote count of the winning class.
REQ-010 SHALL have port out_valid  output  1  outp/out_count are valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.

Function
REQ-012 SHALL implement three states: ACCUM, SCAN, HOLD.
REQ-013 SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in HOLD, both decoded from registered state.
REQ-014 SHALL accept a sample on an edge where in_valid=1 and in_ready=1: vote[inp] += 1, sample count += 1.
REQ-015 SHALL keep eight 8-bit vote counters and one 8-bit sample counter; no wrap is possible since the sum of votes never exceeds WINDOW.
REQ-016 SHALL transition ACCUM->SCAN on the accepting edge at which sample count reaches WINDOW.
REQ-017 SHALL transition ACCUM->SCAN on any edge where flush=1 and sample count, including a sample accepted on that same edge, is >=1.
REQ-018 SHALL ignore flush when no sample is held and none is accepted on that edge, and SHALL ignore flush outside ACCUM.
REQ-019 SHALL, on simultaneous accept and flush, count the sample before closing the window.
REQ-020 SHALL, in SCAN, compare one class per cycle (index 0..7) with a strict greater-than against the running best, so that the lowest class index wins a tie.
REQ-021 SHALL enter HOLD exactly 8 edges after the window-closing edge, with out_valid rising then.
REQ-022 SHALL hold outp and out_count stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on an edge where out_valid=1 and out_ready=1, clear all vote counters and the sample counter and return to ACCUM; in_ready=1 in the following cycle.
REQ-024 SHALL ignore in_valid and inp in SCAN and HOLD; no sample is lost because in_ready=0 there.
REQ-025 SHALL keep outp and out_count holding the last result after the HOLD->ACCUM transition until the next HOLD.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronously), force state=ACCUM, all counters=0, scan index=0, outp=0, out_count=0, out_valid=0.
REQ-027 SHALL, on reset asserted mid-ACCUM, mid-SCAN or mid-HOLD, discard the partial window and resume with an empty window after release.

Verification (WINDOW=8)
REQ-028 SHALL cover: reset pulse -> out_valid=0, outp=0, out_count=0; in_ready=1 first cycle after release.
REQ-029 SHALL cover: 8 accepted samples of class 5 -> out_valid rises 8 edges after 8th accept; outp=5, out_count=8.
REQ-030 SHALL cover: samples 6,6,6,6,3,3,3,3 -> outp=3, out_count=4 (tie to lower index).
REQ-031 SHALL cover: result held with out_ready=0 for 20 cycles while inp toggles -> outp/out_count stable, in_ready=0; then out_ready=1 -> next window starts from zero counts.
REQ-032 SHALL cover: samples 2,2,7 with flush on the third accept -> outp=2, out_count=2; flush with an empty window -> no state change.
REQ-033 SHALL cover: rst_n pulsed during SCAN -> all outputs cleared; the following 8 samples of class 1 -> outp=1, out_count=8.

Source files
------------

// File: rtl/dtc_vote_accum.sv
// Majority-vote accumulator for a decision-tree classifier stream: counts class
// votes over a window, scans for the winner one class per cycle, then holds the result.
module dtc_vote_accum #(
  parameter int unsigned WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] inp,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [2:0] outp,
  output logic [7:0] out_count,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} state_t;

  localparam logic [7:0] WIN = 8'(WINDOW);

  state_t     state, state_nxt;
  logic [7:0] votes [8];
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic [2:0] idx;
  logic [2:0] best_cls;
  logic [7:0] best_cnt;
  logic       accept;
  logic       close;
  logic       release_res;
  logic       better;

  assign in_ready    = (state == ACCUM);
  assign out_valid   = (state == HOLD);
  assign cnt_inc     = cnt + 8'd1;
  assign accept      = in_ready && in_valid;
  // A sample accepted on the flush edge counts toward the non-empty test.
  assign close       = in_ready && ((accept && (cnt_inc == WIN)) ||
                                    (flush && (accept || (cnt != '0))));
  assign release_res = out_valid && out_ready;
  // Strict compare keeps the lowest class index on a tie.
  assign better      = (votes[idx] > best_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close)        state_nxt = SCAN;
      SCAN:    if (idx == 3'd7)  state_nxt = HOLD;
      HOLD:    if (out_ready)    state_nxt = ACCUM;
      default:                   state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) votes[i] <= '0;
      cnt       <= '0;
      idx       <= '0;
      best_cls  <= '0;
      best_cnt  <= '0;
      outp      <= '0;
      out_count <= '0;
    end else begin
      if (release_res) begin
        for (int unsigned i = 0; i < 8; i++) votes[i] <= '0;
        cnt <= '0;
      end else if (accept) begin
        votes[inp] <= votes[inp] + 8'd1;
        cnt        <= cnt_inc;
      end

      if (close) begin
        idx      <= '0;
        best_cls <= '0;
        best_cnt <= '0;
      end

      if (state == SCAN) begin
        idx <= idx + 3'd1;
        if (better) begin
          best_cls <= idx;
          best_cnt <= votes[idx];
        end
        // Last class: publish the final winner straight into the output registers.
        if (idx == 3'd7) begin
          outp      <= better ? idx : best_cls;
          out_count <= better ? votes[idx] : best_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Directed self-checking bench for dtc_vote_accum with WINDOW=8.
module tb_dtc_vote_accum;

  logic       clk;
  logic       rst_n;
  logic [2:0] inp;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [2:0] outp;
  logic [7:0] out_count;
  logic       out_valid;
  logic       out_ready;

  int unsigned n_checks;
  int unsigned n_fail;

  dtc_vote_accum #(.WINDOW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .outp      (outp),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample across a rising edge; returns 1ns after that edge.
  task automatic push(input logic [2:0] c, input logic f);
    in_valid = 1'b1;
    inp      = c;
    flush    = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Count edges until out_valid rises (bounded) and compare to the expected latency.
  task automatic wait_valid(input string tag, input int unsigned exp_edges);
    int unsigned n;
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, n, exp_edges);
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    inp       = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outp", outp, 0);
    check("rst_out_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1);

    // Full window of class 5
    for (int i = 0; i < 8; i++) push(3'd5, 1'b0);
    check("scan_in_ready", in_ready, 0);
    check("scan_out_valid", out_valid, 0);
    wait_valid("lat_full", 8);
    check("full_outp", outp, 5);
    check("full_count", out_count, 8);
    take_result();
    check("ret_in_ready", in_ready, 1);
    check("ret_out_valid", out_valid, 0);
    check("ret_outp_kept", outp, 5);
    check("ret_count_kept", out_count, 8);

    // Tie between 6 and 3 resolves to the lower index
    for (int i = 0; i < 4; i++) push(3'd6, 1'b0);
    for (int i = 0; i < 4; i++) push(3'd3, 1'b0);
    wait_valid("lat_tie", 8);
    check("tie_outp", outp, 3);
    check("tie_count", out_count, 4);

    // Hold with backpressure while inputs toggle
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      inp      = 3'(i);
      @(posedge clk);
      #1;
      check("hold_outp", outp, 3);
      check("hold_count", out_count, 4);
      check("hold_in_ready", in_ready, 0);
      check("hold_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    take_result();
    // Single sample with flush: shows cleared counters and same-edge counting
    push(3'd4, 1'b1);
    wait_valid("lat_single", 8);
    check("single_outp", outp, 4);
    check("single_count", out_count, 1);
    take_result();

    // Flush with an empty window is ignored
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("empty_flush_ready", in_ready, 1);
    @(posedge clk);
    #1;
    check("empty_flush_valid", out_valid, 0);

    // Early close: 2,2,7 with flush on the third accept
    push(3'd2, 1'b0);
    push(3'd2, 1'b0);
    push(3'd7, 1'b1);
    check("flush_in_ready", in_ready, 0);
    wait_valid("lat_flush", 8);
    check("flush_outp", outp, 2);
    check("flush_count", out_count, 2);
    take_result();

    // Reset during SCAN discards the partial window
    push(3'd6, 1'b0);
    push(3'd6, 1'b0);
    push(3'd6, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_outp", outp, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);
    for (int i = 0; i < 7; i++) push(3'd1, 1'b0);
    check("post_rst_7th_ready", in_ready, 1);
    push(3'd1, 1'b0);
    wait_valid("lat_post_rst", 8);
    check("post_rst_outp", outp, 1);
    check("post_rst_count", out_count, 8);
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
